// File: rtl/sine_sweep_ctrl.sv
// sine_sweep_ctrl: steps the sine generator frequency word between start/stop endpoints, one value per dwell period of pls ticks
module sine_sweep_ctrl #(
  parameter int FW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pls,
  input  logic          start,
  input  logic          abort,
  input  logic          mode,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  output logic [FW-1:0] f_set,
  output logic          busy,
  output logic          dir,
  output logic          done,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  state_t        st;
  logic          c_mode;
  logic [FW-1:0] c_start, c_stop, c_step, up_next, dn_next;
  logic [DW-1:0] c_dwell, cnt, in_rl, c_rl;
  logic [FW:0]   inc, dec_lim;
  logic          ok;
  assign ok      = f_step != '0 && f_start <= f_stop;
  assign in_rl   = dwell == '0 ? '0 : dwell - DW'(1);
  assign c_rl    = c_dwell == '0 ? '0 : c_dwell - DW'(1);
  assign inc     = {1'b0, f_set} + {1'b0, c_step};
  assign dec_lim = {1'b0, c_start} + {1'b0, c_step};
  assign up_next = inc >= {1'b0, c_stop} ? c_stop : inc[FW-1:0];
  assign dn_next = {1'b0, f_set} < dec_lim ? c_start : f_set - c_step;
  // sweep FSM: an endpoint is recognised by f_set sitting on it, so the endpoint value always dwells a full period before the turn
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= IDLE;
      f_set   <= '0;
      busy    <= 1'b0;
      dir     <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cnt     <= '0;
      c_mode  <= 1'b0;
      c_start <= '0;
      c_stop  <= '0;
      c_step  <= '0;
      c_dwell <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (st)
        IDLE: if (start && !abort) begin
          if (ok) begin
            st      <= UP;
            busy    <= 1'b1;
            dir     <= 1'b0;
            f_set   <= f_start;
            cnt     <= in_rl;
            c_mode  <= mode;
            c_start <= f_start;
            c_stop  <= f_stop;
            c_step  <= f_step;
            c_dwell <= dwell;
          end else err <= 1'b1;
        end
        default: if (abort) begin
          st   <= IDLE;
          busy <= 1'b0;
          dir  <= 1'b0;
        end else if (pls && cnt != '0) cnt <= cnt - DW'(1);
        else if (pls) begin
          cnt <= c_rl;
          if (st == UP) begin
            if (f_set != c_stop) f_set <= up_next;
            else if (c_mode) begin
              st    <= DOWN;
              dir   <= 1'b1;
              f_set <= dn_next;
            end else begin
              st   <= IDLE;
              busy <= 1'b0;
              done <= 1'b1;
            end
          end else if (f_set != c_start) f_set <= dn_next;
          else begin
            st    <= UP;
            dir   <= 1'b0;
            f_set <= up_next;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// tb_sine_sweep_ctrl: directed plus randomized stimulus against a sequence-list reference model
module tb_sine_sweep_ctrl;
  logic        clk = 0, rst = 0, pls = 0, start = 0, abort = 0, mode = 0;
  logic [15:0] f_start = 0, f_stop = 0, f_step = 0, dwell = 0;
  logic [15:0] f_set;
  logic        busy, dir, done, err;
  int checks = 0, errors = 0;
  // model: the whole sweep is a list of (value,dir) entries, each held for d pls ticks
  int   pre[$], cyc_q[$];
  int   idx, ticks, d;
  bit   m_mode, m_busy, m_dir, m_done, m_err;
  int   m_f;

  sine_sweep_ctrl #(.FW(16), .DW(16)) dut (
    .clk(clk), .rst(rst), .pls(pls), .start(start), .abort(abort), .mode(mode),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .f_set(f_set), .busy(busy), .dir(dir), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic build(input int s, input int e, input int st, input bit md);
    int v;
    pre.delete();
    cyc_q.delete();
    v = s;
    pre.push_back(v);
    while (v != e) begin
      v = (v + st >= e) ? e : v + st;
      pre.push_back(v);
    end
    if (md) begin
      do begin
        v = (v - st < s) ? s : v - st;
        cyc_q.push_back(v | (1 << 16));
      end while (v != s);
      do begin
        v = (v + st >= e) ? e : v + st;
        cyc_q.push_back(v);
      end while (v != e);
    end
  endtask

  task automatic model(input bit s, input bit a, input bit p);
    int e;
    m_done = 0;
    m_err = 0;
    if (!m_busy) begin
      if (s && !a) begin
        if (f_step != 0 && f_start <= f_stop) begin
          build(int'(f_start), int'(f_stop), int'(f_step), mode);
          m_mode = mode;
          d = dwell == 0 ? 1 : int'(dwell);
          idx = 0;
          ticks = 0;
          m_busy = 1;
        end else m_err = 1;
      end
    end else if (a) m_busy = 0;
    else if (p) begin
      ticks++;
      if (ticks == d) begin
        ticks = 0;
        idx++;
        if (!m_mode && idx == pre.size()) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
    m_dir = 0;
    if (m_busy) begin
      e = idx < pre.size() ? pre[idx] : cyc_q[(idx - pre.size()) % cyc_q.size()];
      m_f = e & 32'hFFFF;
      m_dir = e[16];
    end
  endtask

  task automatic cyc(input bit s, input bit a, input bit p);
    start = s;
    abort = a;
    pls = p;
    @(posedge clk);
    model(s, a, p);
    #1;
    chk("f_set", 32'(f_set), 32'(m_f));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("dir", 32'(dir), 32'(m_dir));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
    start = 0;
    abort = 0;
    pls = 0;
  endtask

  task automatic cfg(input bit md, input int s, input int e, input int st, input int dw);
    mode = md;
    f_start = 16'(s);
    f_stop = 16'(e);
    f_step = 16'(st);
    dwell = 16'(dw);
  endtask

  task automatic run(input int n, input int prob);
    for (int i = 0; i < n; i++) cyc(0, 0, $urandom_range(0, 99) < prob);
  endtask

  task automatic rand_cfg();
    int s, st, e;
    st = $urandom_range(1, 4000);
    s = $urandom_range(0, 65535);
    e = s + $urandom_range(0, st * 6);
    if (e > 65535) e = 65535;
    if ($urandom_range(0, 9) == 0) st = 0;
    if ($urandom_range(0, 9) == 0 && s > 0) e = s - 1;
    cfg($urandom_range(0, 1), s, e, st, $urandom_range(0, 3));
  endtask

  initial begin
    bit found;
    m_f = 0;
    #3;
    chk("rst_f_set", 32'(f_set), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done | err | dir), 0);
    #19 rst = 1;
    @(posedge clk);
    #1;
    // single up sweep, pls in the start clk must not count
    cfg(0, 100, 130, 10, 3);
    cyc(1, 0, 1);
    chk("single_first", 32'(f_set), 100);
    run(14, 100);
    chk("single_end", 32'(f_set), 130);
    chk("single_idle", 32'(busy), 0);
    // clamp at stop and no wrap near the top of the word
    cfg(0, 0, 25, 10, 1);
    cyc(1, 0, 0);
    run(8, 100);
    chk("clamp_end", 32'(f_set), 25);
    cfg(0, 16'hFFF0, 16'hFFFF, 16'h20, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    chk("nowrap", 32'(f_set), 32'hFFFF);
    run(4, 100);
    // triangle, abort while descending at 20
    cfg(1, 10, 30, 10, 2);
    cyc(1, 0, 0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc(0, 0, 1);
      found = dir && f_set == 20;
    end
    chk("tri_find", 32'(found), 1);
    cyc(0, 1, 0);
    chk("abort_f", 32'(f_set), 20);
    chk("abort_busy", 32'(busy), 0);
    // rejects and ignored starts
    cfg(0, 5, 50, 0, 1);
    cyc(1, 0, 0);
    chk("rej_step", 32'(err), 1);
    cfg(0, 50, 40, 1, 1);
    cyc(1, 0, 0);
    chk("rej_order", 32'(err), 1);
    cfg(0, 5, 50, 0, 1);
    cyc(1, 1, 0);
    chk("start_abort", 32'(err | busy), 0);
    cfg(0, 0, 30, 10, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    cfg(1, 0, 5, 1, 4);
    cyc(1, 0, 1);
    run(8, 100);
    // equal endpoints in both modes
    cfg(0, 7, 7, 3, 2);
    cyc(1, 0, 0);
    run(4, 100);
    cfg(1, 7, 7, 3, 1);
    cyc(1, 0, 0);
    run(6, 100);
    cyc(0, 1, 0);
    // async reset between edges mid-sweep
    cfg(1, 1000, 2000, 100, 1);
    cyc(1, 0, 0);
    run(5, 100);
    #3 rst = 0;
    #1;
    chk("arst_f_set", 32'(f_set), 0);
    chk("arst_busy", 32'(busy | dir | done | err), 0);
    m_busy = 0;
    m_dir = 0;
    m_f = 0;
    #2 rst = 1;
    @(posedge clk);
    #1;
    run(3, 100);
    // randomized traffic, config inputs churn during sweeps
    for (int i = 0; i < 3000; i++) begin
      bit s, a;
      s = 0;
      a = $urandom_range(0, 99) == 0;
      if (!m_busy && $urandom_range(0, 9) == 0) begin
        rand_cfg();
        s = 1;
      end else if (m_busy) begin
        s = $urandom_range(0, 49) == 0;
        if ($urandom_range(0, 4) == 0) rand_cfg();
      end
      cyc(s, a, $urandom_range(0, 99) < 40);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sine_sweep_ctrl.md
Name: sine_sweep_ctrl

Overview:
Frequency-sweep sequencer that drives the 16-bit f_set input of the sine generator. It steps f_set from a start frequency to a stop frequency, holding each value for a programmable number of 500 kHz pls ticks. It supports a single upward sweep or a continuous triangle (up/down) sweep, and sits between the control/register logic and the sine generator instance.

Parameters:
FW, 16, width of the frequency word (f_start, f_stop, f_step, f_set)
DW, 16, width of the dwell count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
pls  in  1  one-clk strobe at 500 kHz; sole time base for dwell counting
start  in  1  one-clk request to begin a sweep; latches config
abort  in  1  one-clk request to stop the sweep
mode  in  1  0 = single up sweep; 1 = continuous triangle sweep
f_start  in  FW  lowest sweep frequency word
f_stop  in  FW  highest sweep frequency word
f_step  in  FW  increment/decrement per step
dwell  in  DW  pls ticks per frequency value (0 treated as 1)
f_set  out  FW  frequency word to the sine generator
busy  out  1  high while in UP or DOWN
dir  out  1  0 = ascending, 1 = descending
done  out  1  one-clk pulse when a single sweep completes
err  out  1  one-clk pulse when start is rejected

Behaviour:
- Reset (rst=0, async): state=IDLE, f_set=0, busy=0, dir=0, done=0, err=0, dwell counter=0, config registers=0.
- Config registers: mode, f_start, f_stop, f_step and dwell are latched on an accepted start. Input changes during a sweep have no effect.
- State machine: IDLE, UP, DOWN. busy=1 exactly in UP/DOWN. dir=1 exactly in DOWN.
- Start in IDLE, config valid (f_step!=0 and f_start<=f_stop):
  - next clk: state=UP, f_set=f_start.
  - dwell counter loads max(dwell,1)-1.
- Start in IDLE, config invalid: start is ignored, err pulses 1 clk on the next clk, f_set is unchanged.
- start while busy is ignored, with no err.
- Dwell:
  - Each pls with counter!=0 decrements the counter.
  - A pls with counter==0 performs a step and reloads max(dwell,1)-1.
  - pls in the same clk as an accepted start is not counted.
- Step arithmetic uses FW+1 bits, so no wrap-around.
  - UP: if f_set+f_step >= f_stop, then f_set=f_stop and the top is reached; else f_set += f_step.
  - DOWN: if f_set < f_start+f_step (FW+1-bit compare), then f_set=f_start and the bottom is reached; else f_set -= f_step.
- Top reached (f_set has just become f_stop):
  - mode=0: f_set=f_stop dwells one full dwell period. The next step event then goes to IDLE with done=1 for 1 clk; f_set holds f_stop.
  - mode=1: the next step event transitions to DOWN and applies the first decrement in the same clk.
- Bottom reached:
  - mode=1 only: f_set=f_start dwells one full period.
  - The next step event transitions to UP and applies an increment.
- Equal endpoints (f_start==f_stop):
  - mode=0: done pulses after one dwell period.
  - mode=1: f_set stays constant; the FSM alternates UP/DOWN each dwell period until abort.
- abort in UP/DOWN:
  - next clk: IDLE, busy=0, dir=0, f_set holds its current value, no done pulse.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE clk: abort wins and start is ignored (no err).
- Step event coinciding with abort: abort wins and no step is applied.
- f_set, busy, dir, done and err are all registered outputs.
- Mid-sweep reset returns all outputs to reset values immediately (async).

Test Plan:
- Single sweep: mode=0, f_start=100, f_stop=130, f_step=10, dwell=3, one start. Required: f_set=100,110,120,130, each held 3 pls. After the 3rd pls at 130: done pulse, busy=0, f_set stays 130.
- Clamp: mode=0, f_start=0, f_stop=25, f_step=10, dwell=1. Required: f_set=0,10,20,25, then done. Also f_start=0xFFF0, f_stop=0xFFFF, f_step=0x20: f_set=0xFFF0 then 0xFFFF, with no wrap.
- Triangle: mode=1, f_start=10, f_stop=30, f_step=10, dwell=2. Required: 10,20,30,20,10,20,30… with dir=1 only while at descending values, and each value held 2 pls. Abort at f_set=20 (DOWN): busy=0, dir=0, f_set=20, no done.
- Rejects: f_step=0 → err pulse, stays IDLE. f_start=50, f_stop=40 → err pulse. Start during busy → ignored, no err, sweep sequence unchanged.
- Edges: dwell=0 behaves as dwell=1. Start+abort in the same clk → stays IDLE, no err. pls in the start clk is not counted. Config inputs changed mid-sweep do not alter the sequence.
- Async reset asserted mid-sweep, between clk edges: all outputs are 0 immediately. After release, the FSM is in IDLE until the next start.
